mul_sequencer: RTL
==================

# mul_sequencer

Multicycle radix-2 shift-add multiplier with its own sequencing FSM. It executes MUL, UMULL and SMULL for the multicycle ARM core. When the decoder's ALU stage selects a multiply, the main FSM raises `start`. It holds its own state on `stall` until `done`, then writes `result_lo` and, for long multiplies, `result_hi`. The unit replaces a single-cycle combinational multiplier in the ALU path so the multiply does not limit the core clock.

## Interface
Parameters:
- `WIDTH`, 32, operand width; results are 2*`WIDTH`.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  00 MUL, 01 UMULL, 10 SMULL, 11 treated as MUL.
- `a`  in  `WIDTH`  multiplicand (Rn/Rm per decode).
- `b`  in  `WIDTH`  multiplier.
- `stall`  out  1  combinational; main FSM holds its state while high.
- `busy`  out  1  high in CALC.
- `done`  out  1  one-cycle pulse; results valid.
- `result_lo`  out  `WIDTH`  low word of the product.
- `result_hi`  out  `WIDTH`  high word; 0 for MUL.
- `n_flag`  out  1  sign bit of the selected result.
- `z_flag`  out  1  selected result is zero.

## Operation
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on `start`=1.
  - CALC -> DONE when `cnt` = `WIDTH`-1.
  - DONE -> IDLE unconditionally.
- Accept (IDLE & `start`):
  - latch `op`;
  - latch `mcand` = |a| and `mplier` = |b|, where magnitudes are taken only when `op`=10 and the operand MSB is set;
  - latch `neg` = (`op`=10) & (a[MSB] ^ b[MSB]);
  - clear the 2*`WIDTH` accumulator `acc` and clear `cnt`.
- Magnitude arithmetic: |0x80000000| = 0x80000000, treated as unsigned, so there is no overflow.
- CALC, each cycle:
  - if `mplier`[0], then `acc` += `mcand` << `cnt`, computed at 2*`WIDTH` width with the carry discarded;
  - `mplier` >>= 1;
  - `cnt` += 1.
- `cnt` width is clog2(`WIDTH`)+1; it never wraps within one operation.
- The result is formed on the CALC->DONE edge:
  - P = `neg` ? (~acc_final + 1) : acc_final, where acc_final includes the last partial product;
  - MUL: `result_lo` = P[`WIDTH`-1:0], `result_hi` = 0;
  - UMULL/SMULL: `result_lo` = P low word, `result_hi` = P high word.
- Flags:
  - MUL: `n_flag` = P[`WIDTH`-1], `z_flag` = (P low word == 0);
  - long: `n_flag` = P[2*`WIDTH`-1], `z_flag` = (P == 0).
- Results and flags hold their value until the next accept's DONE edge. They do not change at accept.
- `start` in CALC or DONE is ignored; no queueing.
- Operand inputs may change freely after accept.

## Timing
- Reset (`reset`=0, async): state IDLE, `acc`/`cnt`/`mplier`/`mcand` = 0, `result_lo`/`result_hi` = 0, `n_flag`/`z_flag` = 0, `done` = 0, `busy` = 0.
- `stall` = (state==CALC) | (state==IDLE & `start`). It is high in the accept cycle so the main FSM does not advance before the unit is busy.
- `stall` = 0 in DONE.
- Latency: with accept at edge 0, CALC occupies cycles 1..`WIDTH`. `done`=1 in cycle `WIDTH`+1 (cycle 33 for `WIDTH`=32).
- Fixed latency: no early termination on zero operands.
- Back-to-back: `start` held in DONE is ignored. `start` in the IDLE cycle after DONE is accepted, giving a minimum issue interval of `WIDTH`+2 cycles.
- Reset asserted mid-CALC: immediate return to IDLE with all outputs cleared. No `done` is pulsed and the partial result is discarded.
- Reset release: the first `start` is accepted on the first rising edge with `reset`=1.

## Test plan
- MUL 7 x 6, `start` pulsed 1 cycle:
  - `stall`=1 during cycles 0..32 and 0 at cycle 33, where `done`=1;
  - `result_lo`=0x0000002A, `result_hi`=0, `n_flag`=0, `z_flag`=0.
- UMULL 0xFFFFFFFF x 0xFFFFFFFF:
  - `result_hi`=0xFFFFFFFE, `result_lo`=0x00000001, `n_flag`=1.
- SMULL sign cases:
  - 0xFFFFFFFF x 0x00000002: `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFFE, `n_flag`=1;
  - 0x80000000 x 0x80000000: `result_hi`=0x40000000, `result_lo`=0, `n_flag`=0.
- MUL 0x00010000 x 0x00010000:
  - `result_lo`=0, `result_hi`=0, `z_flag`=1.
- Overlap:
  - UMULL 3 x 5 accepted;
  - at cycle 10, pulse `start` with MUL 9 x 9: ignored, and `done` at cycle 33 gives `result_lo`=15, `result_hi`=0;
  - hold `start` with 9 x 9 into DONE: accepted the following IDLE cycle, `done` 33 cycles later with `result_lo`=81.
- Reset mid-op:
  - assert `reset`=0 at CALC cycle 10: all outputs 0 immediately, no `done` pulse;
  - after release, SMULL 0xFFFFFFFD x 0x00000004 gives `result_hi`=0xFFFFFFFF, `result_lo`=0xFFFFFFF4, with `done` at cycle 33.

Source files
------------

// File: rtl/mul_sequencer.sv
// Multicycle radix-2 shift-add multiplier for MUL/UMULL/SMULL.
// Holds the core's main FSM through stall until the product is ready.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             n_flag,
  output logic             z_flag
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] OP_UMULL = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_neg;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result_lo;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_n_flag;
  logic             r_z_flag;

  logic             w_accept;
  logic             w_smull_in;
  logic [WIDTH-1:0] w_mcand_in;
  logic [WIDTH-1:0] w_mplier_in;
  logic             w_neg_in;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_final;
  logic [PW-1:0]    w_prod;
  logic             w_last;
  logic             w_long;
  logic             w_n;
  logic             w_z;

  assign w_accept   = (r_state == IDLE) & start;
  assign w_smull_in = (op == OP_SMULL);

  // Signed operands are reduced to magnitudes; the most negative value maps
  // to itself, which is still the correct unsigned magnitude.
  assign w_mcand_in  = (w_smull_in & a[WIDTH-1]) ? -a : a;
  assign w_mplier_in = (w_smull_in & b[WIDTH-1]) ? -b : b;
  assign w_neg_in    = w_smull_in & (a[WIDTH-1] ^ b[WIDTH-1]);

  assign w_pp        = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
  assign w_acc_final = r_acc + w_pp;
  assign w_prod      = r_neg ? -w_acc_final : w_acc_final;
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  // Opcode 11 falls through to plain MUL behaviour.
  assign w_long = (r_op == OP_UMULL) | (r_op == OP_SMULL);
  assign w_n    = w_long ? w_prod[PW-1] : w_prod[WIDTH-1];
  assign w_z    = w_long ? (w_prod == '0) : (w_prod[WIDTH-1:0] == '0);

  assign stall     = (r_state == CALC) | w_accept;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result_lo = r_result_lo;
  assign result_hi = r_result_hi;
  assign n_flag    = r_n_flag;
  assign z_flag    = r_z_flag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_neg       <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result_lo <= '0;
      r_result_hi <= '0;
      r_n_flag    <= 1'b0;
      r_z_flag    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= CALC;
            r_busy   <= 1'b1;
            r_op     <= op;
            r_mcand  <= w_mcand_in;
            r_mplier <= w_mplier_in;
            r_neg    <= w_neg_in;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_final;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // Result and flags are captured from the final partial sum directly.
          if (w_last) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_result_lo <= w_prod[WIDTH-1:0];
            r_result_hi <= w_long ? w_prod[PW-1:WIDTH] : '0;
            r_n_flag    <= w_n;
            r_z_flag    <= w_z;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
